// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - element size codes and derived-width helpers for the AER SRAM FIFO
package aer_pkg;

    typedef enum logic [1:0] {
        SIZE_B  = 2'd0,
        SIZE_HW = 2'd1,
        SIZE_W  = 2'd2,
        SIZE_DW = 2'd3
    } size_e;

    function automatic int elem_w(input int size);
        return 8 << size;
    endfunction

    function automatic int lanes(input int width, input int size);
        return width / (8 << size);
    endfunction

    // A single-lane word still needs a 1-bit lane signal to keep vectors legal
    function automatic int lane_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/sram_fifo_wrapper_intf.sv
// rtl/sram_fifo_wrapper_intf.sv - fifo-side and SRAM-side signal bundle of sram_byte_fifo
interface sram_fifo_wrapper_intf
    import aer_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MEM_DEPTH = 4096,
    parameter int SIZE      = 3
);
    localparam int ELEM_W = elem_w(SIZE);
    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int PW     = $clog2(MEM_DEPTH * lanes(WIDTH, SIZE));

    logic              rst;
    logic              fifo_clr;
    logic              fifo_wr_en;
    logic [ELEM_W-1:0] fifo_wdata;
    logic              fifo_rd_en;
    logic [ELEM_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW:0]       fifo_numel;
    logic [PW-1:0]     fifo_wr_ptr;
    logic [PW-1:0]     fifo_rd_ptr;
    logic              ce_a;
    logic              we_a;
    logic [AW-1:0]     addr_a;
    logic [WIDTH/8-1:0] wmask_a;
    logic [WIDTH-1:0]  wdata_a;
    logic [WIDTH-1:0]  rdata_a;
    logic              ce_b;
    logic              we_b;
    logic [AW-1:0]     addr_b;
    logic [WIDTH/8-1:0] wmask_b;
    logic [WIDTH-1:0]  wdata_b;
    logic [WIDTH-1:0]  rdata_b;
endinterface

// File: rtl/sram_lane_map.sv
// rtl/sram_lane_map.sv - element pointer to SRAM word address, byte mask and lane index
module sram_lane_map
    import aer_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MEM_DEPTH = 4096,
    parameter int SIZE      = 3,
    localparam int LANES = lanes(WIDTH, SIZE),
    localparam int LB    = $clog2(LANES),
    localparam int LW    = lane_w(LANES),
    localparam int AW    = $clog2(MEM_DEPTH),
    localparam int PW    = $clog2(MEM_DEPTH * LANES),
    localparam int MW    = WIDTH / 8
) (
    input  logic [PW-1:0] ptr_i,
    output logic [AW-1:0] addr_o,
    output logic [MW-1:0] wmask_o,
    output logic [LW-1:0] lane_o
);
    localparam int BPE = 1 << SIZE;
    localparam logic [MW-1:0] BASE_MASK = MW'((1 << BPE) - 1);

    generate
        if (LB == 0) begin : g_one_lane
            assign addr_o = ptr_i[AW-1:0];
            assign lane_o = '0;
        end else begin : g_multi_lane
            assign addr_o = ptr_i[PW-1:LB];
            assign lane_o = ptr_i[LB-1:0];
        end
    endgenerate

    assign wmask_o = BASE_MASK << (int'(lane_o) * BPE);

endmodule

// File: rtl/sram_byte_fifo.sv
// rtl/sram_byte_fifo.sv - FIFO of 8<<SIZE-bit elements packed into an external dual-port SRAM
module sram_byte_fifo
    import aer_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MEM_DEPTH = 4096,
    parameter int SIZE      = 3,
    localparam int ELEM_W     = elem_w(SIZE),
    localparam int LANES      = lanes(WIDTH, SIZE),
    localparam int FIFO_DEPTH = MEM_DEPTH * LANES,
    localparam int AW         = $clog2(MEM_DEPTH),
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int MW         = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_clr,
    input  logic              fifo_wr_en,
    input  logic [ELEM_W-1:0] fifo_wdata,
    input  logic              fifo_rd_en,
    output logic [ELEM_W-1:0] fifo_rdata,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [PW:0]       fifo_numel,
    output logic [PW-1:0]     fifo_wr_ptr,
    output logic [PW-1:0]     fifo_rd_ptr,
    output logic              ce_a,
    output logic              we_a,
    output logic [AW-1:0]     addr_a,
    output logic [MW-1:0]     wmask_a,
    output logic [WIDTH-1:0]  wdata_a,
    output logic              ce_b,
    output logic              we_b,
    output logic [AW-1:0]     addr_b,
    output logic [MW-1:0]     wmask_b,
    output logic [WIDTH-1:0]  wdata_b,
    input  logic [WIDTH-1:0]  rdata_a,
    input  logic [WIDTH-1:0]  rdata_b
);
    localparam int LW = lane_w(LANES);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   numel_q, numel_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [LW-1:0] lane_q, rd_lane;
    logic          zero_q;
    logic          wr_acc, rd_acc;
    logic [LW-1:0] unused_wr_lane;
    logic [MW-1:0] unused_rd_mask;
    logic          unused_rdata_a;

    always_comb begin
        rd_acc   = fifo_rd_en & ~empty_q;
        wr_acc   = fifo_wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        numel_d  = numel_q + (PW+1)'(wr_acc) - (PW+1)'(rd_acc);
        full_d   = (numel_d == (PW+1)'(FIFO_DEPTH));
        empty_d  = (numel_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            numel_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            lane_q   <= '0;
            zero_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            numel_q  <= numel_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            lane_q   <= rd_lane;
            zero_q   <= 1'b0;
        end
    end

    sram_lane_map #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH), .SIZE(SIZE)) u_map_a (
        .ptr_i   (wr_ptr_q),
        .addr_o  (addr_a),
        .wmask_o (wmask_a),
        .lane_o  (unused_wr_lane)
    );

    sram_lane_map #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH), .SIZE(SIZE)) u_map_b (
        .ptr_i   (rd_ptr_q),
        .addr_o  (addr_b),
        .wmask_o (unused_rd_mask),
        .lane_o  (rd_lane)
    );

    // lane_q trails rd_ptr by one cycle so it lines up with the SRAM read latency
    always_comb begin
        fifo_rdata = '0;
        if (!zero_q) begin
            fifo_rdata = ELEM_W'(rdata_b >> (int'(lane_q) * ELEM_W));
        end
    end

    assign ce_a    = wr_acc;
    assign we_a    = wr_acc;
    assign wdata_a = {LANES{fifo_wdata}};
    assign ce_b    = 1'b1;
    assign we_b    = 1'b0;
    assign wmask_b = '0;
    assign wdata_b = '0;

    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign fifo_numel  = numel_q;
    assign fifo_wr_ptr = wr_ptr_q;
    assign fifo_rd_ptr = rd_ptr_q;

    assign unused_rdata_a = ^rdata_a;

endmodule

// File: tb/tb_sram_byte_fifo.sv
// tb/tb_sram_byte_fifo.sv - scoreboard bench for sram_byte_fifo with behavioural SRAM models
module tb_sram_byte_fifo;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT with default parameters, wired through the wrapper bundle
    sram_fifo_wrapper_intf bus ();

    sram_byte_fifo dut (
        .clk(clk), .rst(bus.rst), .fifo_clr(bus.fifo_clr),
        .fifo_wr_en(bus.fifo_wr_en), .fifo_wdata(bus.fifo_wdata), .fifo_rd_en(bus.fifo_rd_en),
        .fifo_rdata(bus.fifo_rdata), .fifo_full(bus.fifo_full), .fifo_empty(bus.fifo_empty),
        .fifo_numel(bus.fifo_numel), .fifo_wr_ptr(bus.fifo_wr_ptr), .fifo_rd_ptr(bus.fifo_rd_ptr),
        .ce_a(bus.ce_a), .we_a(bus.we_a), .addr_a(bus.addr_a), .wmask_a(bus.wmask_a),
        .wdata_a(bus.wdata_a), .ce_b(bus.ce_b), .we_b(bus.we_b), .addr_b(bus.addr_b),
        .wmask_b(bus.wmask_b), .wdata_b(bus.wdata_b), .rdata_a(bus.rdata_a), .rdata_b(bus.rdata_b)
    );

    logic [63:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ce_a && bus.we_a)
            for (int b = 0; b < 8; b++)
                if (bus.wmask_a[b]) mem[bus.addr_a][b*8 +: 8] <= bus.wdata_a[b*8 +: 8];
        if (bus.ce_b && !bus.we_b) bus.rdata_b <= mem[bus.addr_b];
    end

    // SIZE=0 DUT: 8 byte lanes per word, 4 words -> 32 elements
    logic        clr0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0;
    logic [7:0]  wd0 = '0, rdata0;
    logic        full0, empty0, ce_a0, we_a0, ce_b0, we_b0;
    logic [5:0]  numel0;
    logic [4:0]  wr_ptr0, rd_ptr0;
    logic [1:0]  addr_a0, addr_b0;
    logic [7:0]  wmask_a0, wmask_b0;
    logic [63:0] wdata_a0, wdata_b0, rdata_b0;
    logic [63:0] mem0 [4];

    sram_byte_fifo #(.WIDTH(64), .MEM_DEPTH(4), .SIZE(0)) dut0 (
        .clk(clk), .rst(bus.rst), .fifo_clr(clr0),
        .fifo_wr_en(wr0), .fifo_wdata(wd0), .fifo_rd_en(rd0),
        .fifo_rdata(rdata0), .fifo_full(full0), .fifo_empty(empty0),
        .fifo_numel(numel0), .fifo_wr_ptr(wr_ptr0), .fifo_rd_ptr(rd_ptr0),
        .ce_a(ce_a0), .we_a(we_a0), .addr_a(addr_a0), .wmask_a(wmask_a0),
        .wdata_a(wdata_a0), .ce_b(ce_b0), .we_b(we_b0), .addr_b(addr_b0),
        .wmask_b(wmask_b0), .wdata_b(wdata_b0), .rdata_a(64'd0), .rdata_b(rdata_b0)
    );

    always @(posedge clk) begin
        if (ce_a0 && we_a0)
            for (int b = 0; b < 8; b++)
                if (wmask_a0[b]) mem0[addr_a0][b*8 +: 8] <= wdata_a0[b*8 +: 8];
        if (ce_b0 && !we_b0) rdata_b0 <= mem0[addr_b0];
    end

    logic [63:0] q  [$];
    logic [7:0]  q0 [$];
    int          exp_cnt = 0;

    // Monitors: every accepted pop must present the oldest outstanding element
    always @(negedge clk) begin
        logic [63:0] e;
        if (!bus.rst && bus.fifo_rd_en && !bus.fifo_empty) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_rdata: pop with empty scoreboard, got %h", bus.fifo_rdata);
            end else begin
                e = q.pop_front();
                if (bus.fifo_rdata !== e) begin
                    n_err++;
                    $display("FAIL sb_rdata: got %h want %h", bus.fifo_rdata, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!bus.rst && rd0 && !empty0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_rdata: pop with empty scoreboard, got %h", rdata0);
            end else begin
                e = q0.pop_front();
                if (rdata0 !== e) begin
                    n_err++;
                    $display("FAIL sb0_rdata: got %h want %h", rdata0, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [31:0] h;
        h = 32'(i) * 32'h9E37_79B9;
        return {16'hC0DE, 16'(i), h};
    endfunction

    task automatic cyc(input bit w, input bit r, input logic [63:0] d);
        bit wa, ra;
        ra = r && (exp_cnt > 0);
        wa = w && ((exp_cnt < DEPTH) || ra);
        bus.fifo_wr_en = w;
        bus.fifo_rd_en = r;
        bus.fifo_wdata = d;
        if (wa) q.push_back(d);
        exp_cnt = exp_cnt + int'(wa) - int'(ra);
        @(posedge clk); #1;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_rd_en = 1'b0;
    endtask

    task automatic push(input logic [63:0] d);
        cyc(1'b1, 1'b0, d);
        cyc(1'b0, 1'b0, 64'd0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b1, 64'd0);
        cyc(1'b0, 1'b0, 64'd0);
    endtask

    task automatic cyc0(input bit w, input bit r, input logic [7:0] d,
                        input bit chk_map, input logic [1:0] ea, input logic [7:0] em);
        wr0 = w;
        rd0 = r;
        wd0 = d;
        if (w) q0.push_back(d);
        #1;
        if (chk_map) begin
            chk("t5_we_a", 64'(we_a0), 64'd1);
            chk("t5_addr_a", 64'(addr_a0), 64'(ea));
            chk("t5_wmask_a", 64'(wmask_a0), 64'(em));
        end
        @(posedge clk); #1;
        wr0 = 1'b0;
        rd0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] m;
        bus.rst = 1'b1;
        bus.fifo_clr = 1'b0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_rd_en = 1'b0;
        bus.fifo_wdata = '0;
        bus.rdata_a = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_numel", 64'(bus.fifo_numel), 64'd0);
        chk("rst_empty", 64'(bus.fifo_empty), 64'd1);
        chk("rst_full", 64'(bus.fifo_full), 64'd0);
        chk("rst_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd0);
        chk("rst_rd_ptr", 64'(bus.fifo_rd_ptr), 64'd0);
        chk("rst_rdata", bus.fifo_rdata, 64'd0);
        bus.rst = 1'b0;
        @(posedge clk); #1;

        // 1: fill to full, then drain
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("t1_not_full_early", 64'(bus.fifo_full), 64'd0);
            push(pat(i));
        end
        chk("t1_full", 64'(bus.fifo_full), 64'd1);
        chk("t1_numel", 64'(bus.fifo_numel), 64'd4096);
        chk("t1_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd0);
        for (int i = 0; i < DEPTH; i++) pop();
        chk("t1_empty", 64'(bus.fifo_empty), 64'd1);
        chk("t1_numel_end", 64'(bus.fifo_numel), 64'd0);

        // 3: half fill, drain
        for (int i = 0; i < 2048; i++) push(pat(i + 10000));
        for (int i = 0; i < 2048; i++) pop();
        chk("t3_rd_ptr", 64'(bus.fifo_rd_ptr), 64'd2048);
        chk("t3_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd2048);
        chk("t3_numel", 64'(bus.fifo_numel), 64'd0);

        // 4: soft clear at half occupancy
        for (int i = 0; i < 2048; i++) push(pat(i + 20000));
        chk("t4_numel_pre", 64'(bus.fifo_numel), 64'd2048);
        bus.fifo_clr = 1'b1;
        @(posedge clk); #1;
        bus.fifo_clr = 1'b0;
        q.delete();
        exp_cnt = 0;
        chk("t4_numel", 64'(bus.fifo_numel), 64'd0);
        chk("t4_empty", 64'(bus.fifo_empty), 64'd1);
        chk("t4_full", 64'(bus.fifo_full), 64'd0);
        chk("t4_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd0);
        chk("t4_rd_ptr", 64'(bus.fifo_rd_ptr), 64'd0);
        chk("t4_rdata", bus.fifo_rdata, 64'd0);

        // 2: simultaneous wr+rd on empty FIFO
        cyc(1'b1, 1'b1, 64'hA5A5_0000_FFFF_1234);
        chk("t2_numel", 64'(bus.fifo_numel), 64'd1);
        chk("t2_rd_ptr", 64'(bus.fifo_rd_ptr), 64'd0);
        cyc(1'b0, 1'b0, 64'd0);
        chk("t2_rdata", bus.fifo_rdata, 64'hA5A5_0000_FFFF_1234);
        pop();
        chk("t2_empty", 64'(bus.fifo_empty), 64'd1);

        // 6: full behaviour (pointers start at 1)
        for (int i = 0; i < DEPTH; i++) push(pat(i + 30000));
        chk("t6_full", 64'(bus.fifo_full), 64'd1);
        cyc(1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t6_ign_numel", 64'(bus.fifo_numel), 64'd4096);
        chk("t6_ign_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd1);
        cyc(1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
        chk("t6_wr_rd_numel", 64'(bus.fifo_numel), 64'd4096);
        chk("t6_wr_ptr", 64'(bus.fifo_wr_ptr), 64'd2);
        chk("t6_rd_ptr", 64'(bus.fifo_rd_ptr), 64'd2);
        chk("t6_full_kept", 64'(bus.fifo_full), 64'd1);

        // 5: SIZE=0 byte lanes
        for (int i = 0; i < 9; i++) begin
            m = (i < 8) ? 8'(1 << i) : 8'h01;
            cyc0(1'b1, 1'b0, 8'(8'h11 * (i + 1)), 1'b1, (i < 8) ? 2'd0 : 2'd1, m);
        end
        chk("t5_numel", 64'(numel0), 64'd9);
        for (int i = 0; i < 9; i++) cyc0(1'b0, 1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        chk("t5_empty", 64'(empty0), 64'd1);
        chk("t5_rd_ptr", 64'(rd_ptr0), 64'd9);
        chk("t5_sb_drained", 64'(q0.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
